// File: rtl/cpu_pkg.sv
// Shared types and constants for the MIPS core front end: fetch FSM states,
// the IF/ID payload and the reset defaults used by the fetch stage.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0000;

   // Explicit encodings keep the state values stable for older tooling
   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        valid;
   } if_id_t;

   localparam if_id_t IF_ID_RESET = '{instr: NOP, pc_plus4: 32'h0000_0000, valid: 1'b0};

   // Jump targets are forced onto a word boundary before they reach the PC
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Load captures a fetched word, flush turns the
// register into a bubble while keeping the old payload, otherwise it holds.
module if_id_reg
   import cpu_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  logic   flush,
   input  if_id_t load_data,
   output if_id_t q
);

   // Flush wins over load so a redirect can never let a stale word through
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= IF_ID_RESET;
      end else if (flush) begin
         q.valid <= 1'b0;
      end else if (load) begin
         q <= load_data;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests,
// fills the IF/ID register and applies (or buffers, when stalled) redirects
// coming back from the ID stage.
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_f,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_plus4_d,
   output logic        valid_d,
   output logic        misalign_err
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pend_addr;
   logic         misalign_q;

   logic         transfer;
   logic         apply_run;
   logic         apply_pend;
   logic         apply_redirect;
   logic         capture_pend;
   logic [31:0]  target;
   logic [31:0]  pc_next_seq;
   logic         if_id_load;
   logic         if_id_flush;
   if_id_t       if_id_in;
   if_id_t       if_id_q;

   // Decode the current cycle: request, completed transfer, and whether a
   // redirect target gets applied now or must be parked until the stall ends
   always_comb begin
      imem_req       = (state == RUN) && !stall_f;
      transfer       = imem_req && imem_ready;
      apply_run      = (state == RUN) && redirect_valid && !stall_f;
      apply_pend     = (state == PEND) && !stall_f;
      apply_redirect = apply_run || apply_pend;
      capture_pend   = redirect_valid && stall_f && (state != BOOT);
      target         = ((state == PEND) && !redirect_valid) ? pend_addr : redirect_addr;
      pc_next_seq    = pc + 32'd4;
      if_id_load     = transfer && !redirect_valid;
      if_id_flush    = ((state == RUN) && !stall_f && !if_id_load) || apply_pend;
      if_id_in       = '{instr: imem_rdata, pc_plus4: pc_next_seq, valid: 1'b1};
   end

   // Fetch FSM: one boot cycle, then run, detouring through PEND while a
   // redirect is waiting for the stall to release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
      end else begin
         case (state)
            BOOT: state <= RUN;
            RUN:  if (redirect_valid && stall_f) state <= PEND;
            PEND: if (!stall_f) state <= RUN;
            default: state <= BOOT;
         endcase
      end
   end

   // Parked redirect target; a newer redirect during the stall replaces it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_addr <= 32'h0000_0000;
      end else if (capture_pend) begin
         pend_addr <= redirect_addr;
      end
   end

   // Program counter: redirect beats sequential advance, which needs a transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (apply_redirect) begin
         pc <= align_word(target);
      end else if (if_id_load) begin
         pc <= pc_next_seq;
      end
   end

   // Flag a misaligned target in the same cycle the aligned PC shows up
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= apply_redirect && (target[1:0] != 2'b00);
      end
   end

   if_id_reg u_if_id_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (if_id_load),
      .flush     (if_id_flush),
      .load_data (if_id_in),
      .q         (if_id_q)
   );

   assign imem_addr    = pc;
   assign pc_f         = pc;
   assign instr_d      = if_id_q.instr;
   assign pc_plus4_d   = if_id_q.pc_plus4;
   assign valid_d      = if_id_q.valid;
   assign misalign_err = misalign_q;

endmodule
